count_key_sched: RTL and testbench
==================================

# count_key_sched

Controller that shares one modulo counter register among four debounced push-buttons. It detects press events on each key, latches them as pending requests, and grants them round-robin. It applies the granted operation (increment, decrement, load preset, clear) to the counter and presents the result to a downstream consumer (display/LED driver) over a valid/ready handshake. It sits between the per-key debouncers and the display logic; increment and decrement keys auto-repeat while held.

## Interface
- WIDTH, 8: counter width.
- MAX, 8'd99: counter upper bound; the count range is 0..MAX (MAX ≤ 2^WIDTH−1).
- PRESET, 8'd50: value written by the load key.
- PRESS_LEVEL, 1'b0: key_db level that means "pressed".
- HOLD_CYCLES, 8: cycles a key 0 or key 1 press must be held before the first auto-repeat.
- REPEAT_CYCLES, 4: cycles between subsequent auto-repeats.
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- key_db  in  4  debounced key levels:
  - [0] increment
  - [1] decrement
  - [2] load PRESET
  - [3] clear
- cnt  out  WIDTH  current counter value.
- cnt_valid  out  1  cnt holds a newly updated value awaiting acceptance.
- cnt_ready  in  1  consumer accepts the update when sampled high with cnt_valid.
- grant_idx  out  2  index of the key whose operation produced the current cnt.
- wrap  out  1  the current update wrapped (increment MAX→0 or decrement 0→MAX). Valid with cnt_valid.
- busy  out  1  FSM not in IDLE, or any request pending.

## Operation
- **Edge detect:** key_prev[i] registers key_db[i]. A press event on key i occurs when key_db[i]==PRESS_LEVEL and key_prev[i]!=PRESS_LEVEL. A press event sets pending[i] on the next edge.
- **Auto-repeat (keys 0 and 1 only):** a per-key hold counter clears on a press event or on release.
  - The counter increments each cycle while the key stays at PRESS_LEVEL.
  - When it reaches HOLD_CYCLES, the block sets pending[i] and reloads the counter so that further sets occur every REPEAT_CYCLES while the key is held.
  - Keys 2 and 3 never repeat.
- **Request merging:** pending is a single bit per key. Events on an already-pending key merge; they do not queue.
- **FSM states:** IDLE, EXEC, OUT.
  - **IDLE:** if pending≠0, select the first set bit searching from ptr, ptr+1, … mod 4. Latch it as grant_idx and go to EXEC. Otherwise stay in IDLE.
  - **EXEC:** apply the operation:
    - increment: cnt = (cnt==MAX) ? 0 : cnt+1
    - decrement: cnt = (cnt==0) ? MAX : cnt−1
    - load: cnt = PRESET
    - clear: cnt = 0
  - **EXEC (continued):** set wrap to reflect whether the operation wrapped. Clear pending[grant_idx]. Set ptr = grant_idx+1 mod 4. Assert cnt_valid and go to OUT.
  - **OUT:** hold cnt, wrap, grant_idx and cnt_valid stable until cnt_ready==1, then deassert cnt_valid and return to IDLE.
- **Pending set and clear in the same cycle:** if a new event on key i coincides with the EXEC clear of pending[i], the set wins and pending[i] stays 1.
- **Pending during OUT:** pending requests keep accumulating while in OUT. Nothing is lost except same-key merges.
- **Reset:**
  - cnt=0, cnt_valid=0, wrap=0, grant_idx=0, busy=0.
  - pending=0, ptr=0, state IDLE, hold counters 0.
  - key_prev = ~PRESS_LEVEL, so a key held through reset yields exactly one press event after reset release.
- **Reset mid-operation:** reset in EXEC or OUT aborts the operation. No update is delivered and cnt returns to 0.

## Timing
- key_db reaches PRESS_LEVEL before edge k:
  - pending set at edge k
  - EXEC entered at edge k+1
  - cnt and cnt_valid updated at edge k+2
- With cnt_ready tied to 1:
  - IDLE is re-entered at edge k+3.
  - Minimum service period is 3 cycles per operation.
- cnt changes only on the EXEC→OUT edge. It is never altered while cnt_valid is high.
- cnt_valid rises exactly one edge after EXEC and falls on the edge after cnt_ready is sampled high.
- First auto-repeat pending set: HOLD_CYCLES cycles after the press pending set. Subsequent sets follow every REPEAT_CYCLES cycles.
- busy is combinational from state and pending.

## Test plan
- **Reset, then single increment:** reset, then press key0 once with cnt_ready=1 → cnt=1, cnt_valid high for 1 cycle, grant_idx=0, wrap=0, 2 cycles after the pending set.
- **Wrap both ways:** clear, then press key1 → cnt=99 with wrap=1. Then press key0 → cnt=0 with wrap=1.
- **Simultaneous presses:** press all four keys in the same cycle with cnt=10 and ptr=0 → updates delivered in order:
  - grant 0 (cnt 11)
  - grant 1 (10)
  - grant 2 (50)
  - grant 3 (0)
  - One update every 3 cycles.
- **Backpressure:** hold cnt_ready=0 for 20 cycles after a key2 press → cnt=50 and cnt_valid stay stable. A key0 press during the stall is delivered (51) after cnt_ready rises.
- **Auto-repeat:** hold key0 for HOLD_CYCLES+3×REPEAT_CYCLES cycles from cnt=0 → exactly 4 increments, final cnt=4. Holding key3 gives 1 clear only.
- **Reset mid-operation:** assert rst while in OUT with cnt_valid=1 → next cycle cnt=0, cnt_valid=0, pending=0. A key held through reset produces one update after release of rst.

Source files
------------

// File: rtl/count_key_sched_if.sv
// Update channel from count_key_sched to its display/LED consumer.
// The master side presents a new counter value with cnt_valid and holds it
// until the slave accepts it with cnt_ready.
interface count_key_sched_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] cnt;
  logic             cnt_valid;
  logic             cnt_ready;
  logic [1:0]       grant_idx;
  logic             wrap;

  modport master (
    output cnt,
    output cnt_valid,
    output grant_idx,
    output wrap,
    input  cnt_ready
  );

  modport slave (
    input  cnt,
    input  cnt_valid,
    input  grant_idx,
    input  wrap,
    output cnt_ready
  );
endinterface

// File: rtl/count_key_sched.sv
// count_key_sched: four debounced keys share one modulo counter.
// Press events (plus auto-repeat on the inc/dec keys) set one pending bit per
// key; a round-robin arbiter grants one request at a time, the granted
// operation is applied in EXEC, and the result is offered downstream in OUT
// over a valid/ready handshake.
module count_key_sched #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] MAX           = WIDTH'(99),
  parameter logic [WIDTH-1:0] PRESET        = WIDTH'(50),
  parameter logic             PRESS_LEVEL   = 1'b0,
  parameter int               HOLD_CYCLES   = 8,
  parameter int               REPEAT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_db,
  count_key_sched_if.master bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Key operation codes, indexed by key number.
  localparam logic [1:0] KEY_INC   = 2'd0;
  localparam logic [1:0] KEY_DEC   = 2'd1;
  localparam logic [1:0] KEY_LOAD  = 2'd2;
  localparam logic [1:0] KEY_CLEAR = 2'd3;

  // Hold counter only ever needs to reach HOLD_CYCLES.
  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HCW-1:0] HOLD_TOP    = HCW'(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_RELOAD = HCW'(HOLD_CYCLES - REPEAT_CYCLES);

  // Released level for all four keys; key_prev starts here so a key held
  // through reset produces exactly one press event afterwards.
  localparam logic [3:0] KEYS_RELEASED = {4{~PRESS_LEVEL}};

  state_t           state_q, state_nxt;
  logic [3:0]       key_prev;
  logic [3:0]       pending_q, pending_nxt;
  logic [1:0]       ptr_q, ptr_nxt;
  logic [1:0]       grant_q, grant_nxt;
  logic [WIDTH-1:0] cnt_q, cnt_nxt;
  logic             wrap_q, wrap_nxt;
  logic             valid_q, valid_nxt;
  logic [HCW-1:0]   hold_cnt [2];
  logic [HCW-1:0]   hold_nxt [2];
  logic [HCW-1:0]   hold_inc [2];

  logic [3:0]       pressed;
  logic [3:0]       was_pressed;
  logic [3:0]       press_evt;
  logic [1:0]       rep_set;
  logic [3:0]       set_mask;
  logic [3:0]       clr_mask;

  // First requesting key found scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    logic [1:0] pick;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Level and edge view of the keys in "pressed" polarity.
  assign pressed     = ~(key_db   ^ {4{PRESS_LEVEL}});
  assign was_pressed = ~(key_prev ^ {4{PRESS_LEVEL}});
  assign press_evt   = pressed & ~was_pressed;

  // Auto-repeat timers for the increment and decrement keys.
  // NOTE: every signal written here gets a value before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rep_set = '0;
    for (int i = 0; i < 2; i++) begin
      hold_inc[i] = hold_cnt[i] + HCW'(1);
      hold_nxt[i] = '0;
      if (pressed[i] && !press_evt[i]) begin
        if (hold_inc[i] == HOLD_TOP) begin
          rep_set[i]  = 1'b1;
          hold_nxt[i] = HOLD_RELOAD;
        end else begin
          hold_nxt[i] = hold_inc[i];
        end
      end
    end
  end

  // Pending requests: a new set beats a same-cycle clear from EXEC.
  always_comb begin
    set_mask    = press_evt | {2'b00, rep_set};
    pending_nxt = (pending_q & ~clr_mask) | set_mask;
  end

  // FSM next state plus the datapath updates made on each transition.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    wrap_nxt  = wrap_q;
    valid_nxt = valid_q;
    grant_nxt = grant_q;
    ptr_nxt   = ptr_q;
    clr_mask  = '0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_nxt = rr_pick(pending_q, ptr_q);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        unique case (grant_q)
          KEY_INC: begin
            wrap_nxt = (cnt_q == MAX);
            cnt_nxt  = (cnt_q == MAX) ? '0 : cnt_q + WIDTH'(1);
          end
          KEY_DEC: begin
            wrap_nxt = (cnt_q == '0);
            cnt_nxt  = (cnt_q == '0) ? MAX : cnt_q - WIDTH'(1);
          end
          KEY_LOAD: begin
            wrap_nxt = 1'b0;
            cnt_nxt  = PRESET;
          end
          KEY_CLEAR: begin
            wrap_nxt = 1'b0;
            cnt_nxt  = '0;
          end
          default: begin
            wrap_nxt = 1'b0;
            cnt_nxt  = cnt_q;
          end
        endcase
        clr_mask[grant_q] = 1'b1;
        ptr_nxt           = grant_q + 2'd1;
        valid_nxt         = 1'b1;
        state_nxt         = OUT;
      end
      OUT: begin
        if (bus.cnt_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and request registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_prev  <= KEYS_RELEASED;
      pending_q <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      valid_q   <= 1'b0;
      // NOTE: the two-entry hold array is plain flops, so it is reset with the
      // rest; a larger RAM-style array would be left unreset.
      for (int i = 0; i < 2; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      state_q   <= state_nxt;
      key_prev  <= key_db;
      pending_q <= pending_nxt;
      ptr_q     <= ptr_nxt;
      grant_q   <= grant_nxt;
      cnt_q     <= cnt_nxt;
      wrap_q    <= wrap_nxt;
      valid_q   <= valid_nxt;
      for (int i = 0; i < 2; i++) begin
        hold_cnt[i] <= hold_nxt[i];
      end
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.cnt_valid = valid_q;
  assign bus.grant_idx = grant_q;
  assign bus.wrap      = wrap_q;
  assign busy          = (state_q != IDLE) || (|pending_q);

endmodule

// File: tb/tb_count_key_sched.sv
// Directed bench for count_key_sched: expected updates (value, grant, wrap and
// the cycle they should appear) are queued when keys are driven and checked
// when the consumer accepts them.
module tb_count_key_sched;

  typedef struct {
    logic [7:0] cnt;
    logic [1:0] grant;
    logic       wrap;
    int         at;
  } upd_t;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] key_db = 4'hF;
  logic       busy;

  int   cyc       = 0;
  int   n_vec     = 0;
  int   n_fail    = 0;
  int   model_cnt = 0;
  int   k;
  int   c;
  upd_t sb[$];

  count_key_sched_if #(.WIDTH(8)) bus ();

  count_key_sched dut (
    .clk    (clk),
    .rst    (rst),
    .key_db (key_db),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one granted key operation.
  function automatic void push_op(input int idx, input int at);
    upd_t e;
    e.grant = 2'(idx);
    e.wrap  = 1'b0;
    e.at    = at;
    case (idx)
      0: begin
        e.wrap    = (model_cnt == 99);
        model_cnt = e.wrap ? 0 : model_cnt + 1;
      end
      1: begin
        e.wrap    = (model_cnt == 0);
        model_cnt = e.wrap ? 99 : model_cnt - 1;
      end
      2:       model_cnt = 50;
      default: model_cnt = 0;
    endcase
    e.cnt = 8'(model_cnt);
    sb.push_back(e);
  endfunction

  // Compare an update being accepted at this edge against the queue head.
  task automatic poll();
    upd_t e;
    if (bus.cnt_valid === 1'b1 && bus.cnt_ready === 1'b1) begin
      n_vec++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_update: observed cnt %0d grant %0d expected no update",
               bus.cnt, bus.grant_idx);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("upd_cnt",   32'(bus.cnt),       32'(e.cnt));
        check("upd_grant", 32'(bus.grant_idx), 32'(e.grant));
        check("upd_wrap",  32'(bus.wrap),      32'(e.wrap));
        if (e.at >= 0) check("upd_cycle", cyc, e.at);
      end
    end
  endtask

  task automatic drain(input int budget);
    int w;
    w = 0;
    while (sb.size() > 0 && w < budget) begin
      @(negedge clk);
      poll();
      w++;
    end
    n_vec++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d outstanding expected 0", sb.size());
      sb.delete();
    end
    repeat (4) begin
      @(negedge clk);
      poll();
    end
    check("idle_busy", busy, 0);
  endtask

  // Drive the masked keys to the pressed level (0) for 'hold' sampling edges.
  task automatic press(input logic [3:0] mask, input int hold);
    key_db = key_db & ~mask;
    repeat (hold) begin
      @(negedge clk);
      poll();
    end
    key_db = key_db | mask;
  endtask

  initial begin
    bus.cnt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cnt",   bus.cnt,       0);
    check("rst_valid", bus.cnt_valid, 0);
    check("rst_wrap",  bus.wrap,      0);
    check("rst_grant", bus.grant_idx, 0);
    check("rst_busy",  busy,          0);
    rst = 1'b0;

    // Single increment: update two edges after the pending set.
    k = cyc + 1;
    push_op(0, k + 2);
    press(4'b0001, 1);
    check("pend_busy",  busy,          1);
    check("pend_valid", bus.cnt_valid, 0);
    drain(20);

    // Clear, then wrap downward and upward.
    push_op(3, cyc + 3); press(4'b1000, 1); drain(20);
    push_op(1, cyc + 3); press(4'b0010, 1); drain(20);
    push_op(0, cyc + 3); press(4'b0001, 1); drain(20);

    // Clear leaves ptr at 0; then all four keys at once.
    push_op(3, cyc + 3); press(4'b1000, 1); drain(20);
    k = cyc + 1;
    push_op(0, k + 2);
    push_op(1, k + 5);
    push_op(2, k + 8);
    push_op(3, k + 11);
    press(4'b1111, 1);
    drain(40);

    // Count up to 10 (ptr ends at 1), then all four again: order 1,2,3,0.
    for (int i = 0; i < 10; i++) begin
      push_op(0, cyc + 3);
      press(4'b0001, 1);
      drain(20);
    end
    check("ten_cnt", bus.cnt, 10);
    k = cyc + 1;
    push_op(1, k + 2);
    push_op(2, k + 5);
    push_op(3, k + 8);
    push_op(0, k + 11);
    press(4'b1111, 1);
    drain(40);

    // New press on key 0 lands on the same edge EXEC clears it: set wins.
    k = cyc + 1;
    push_op(0, k + 2);
    push_op(0, k + 5);
    press(4'b0001, 1);
    @(negedge clk);
    poll();
    press(4'b0001, 1);
    drain(20);

    // Backpressure: load held for 20 cycles, key 0 pressed during the stall.
    bus.cnt_ready = 1'b0;
    push_op(2, -1);
    press(4'b0100, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        push_op(0, -1);
        key_db[0] = 1'b0;
      end
      if (i == 6) key_db[0] = 1'b1;
      check("stall_cnt",   bus.cnt,       50);
      check("stall_valid", bus.cnt_valid, 1);
      check("stall_grant", bus.grant_idx, 2);
      @(negedge clk);
    end
    check("stall_busy", busy, 1);
    bus.cnt_ready = 1'b1;
    c = cyc;
    sb[0].at = c;
    sb[1].at = c + 3;
    poll();
    drain(20);

    // Auto-repeat from 0: press + 3 repeats over HOLD+3*REPEAT held edges.
    push_op(3, cyc + 3); press(4'b1000, 1); drain(20);
    k = cyc + 1;
    push_op(0, k + 2);
    push_op(0, k + 10);
    push_op(0, k + 14);
    push_op(0, k + 18);
    press(4'b0001, 20);
    drain(30);
    check("repeat_final", bus.cnt, 4);

    // Clear key held just as long: exactly one clear.
    k = cyc + 1;
    push_op(3, k + 2);
    press(4'b1000, 20);
    drain(30);

    // Reset while an update waits in OUT; key 1 held through reset.
    bus.cnt_ready = 1'b0;
    press(4'b0001, 1);
    repeat (2) @(negedge clk);
    check("pre_rst_valid", bus.cnt_valid, 1);
    check("pre_rst_cnt",   bus.cnt,       1);
    rst       = 1'b1;
    key_db[1] = 1'b0;
    @(negedge clk);
    model_cnt = 0;
    check("midrst_cnt",   bus.cnt,       0);
    check("midrst_valid", bus.cnt_valid, 0);
    check("midrst_busy",  busy,          0);
    @(negedge clk);
    bus.cnt_ready = 1'b1;
    rst           = 1'b0;
    push_op(1, cyc + 3);
    press(4'b0010, 1);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
